// File: rtl/haar_stage_evaluator.sv
// Streaming Haar cascade stage evaluator: reads a stage header and classifier records, fetches
// integral-image corners, accumulates leaf values. Optional macro HAAR_SUM_SAT_EN saturates the sum.
module haar_stage_evaluator #(
  parameter int DATA_WIDTH    = 12,
  parameter int NUM_RECTS     = 3,
  parameter int II_WIDTH      = 20,
  parameter int II_ADDR_WIDTH = 7,
  parameter int SUM_WIDTH     = 24,
  parameter int COUNT_WIDTH   = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     db_valid,
  input  logic [DATA_WIDTH-1:0]    db_data,
  output logic                     db_ready,
  output logic                     ii_rd,
  output logic [II_ADDR_WIDTH-1:0] ii_addr,
  input  logic [II_WIDTH-1:0]      ii_rdata,
  output logic                     busy,
  output logic                     done,
  output logic                     candidate,
  output logic [SUM_WIDTH-1:0]     stage_sum
);
  localparam int W      = 5 * NUM_RECTS + 3;
  localparam int NF     = 4 * NUM_RECTS;
  localparam int RECT_W = II_WIDTH + 2;
  localparam int VAL_W  = RECT_W + DATA_WIDTH + 2;
  localparam int ACC_W  = ((SUM_WIDTH > DATA_WIDTH) ? SUM_WIDTH : DATA_WIDTH) + 1;
  localparam int WC_W   = $clog2(W + 1);
  localparam int FC_W   = $clog2(NF + 1);
  localparam logic signed [SUM_WIDTH-1:0] SUM_POS = {1'b0, {(SUM_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_WIDTH-1:0] SUM_NEG = {1'b1, {(SUM_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_LOAD, S_FETCH, S_EVAL, S_DONE} state_t;

  state_t                         state_q, state_d;
  logic [DATA_WIDTH-1:0]          rec_q [W];
  logic [DATA_WIDTH-1:0]          rec_d [W];
  logic [II_WIDTH-1:0]            samp_q [NF];
  logic [II_WIDTH-1:0]            samp_d [NF];
  logic [WC_W-1:0]                word_cnt_q, word_cnt_d;
  logic [FC_W-1:0]                fetch_cnt_q, fetch_cnt_d;
  logic [COUNT_WIDTH-1:0]         cls_left_q, cls_left_d;
  logic signed [DATA_WIDTH-1:0]   stage_thr_q, stage_thr_d;
  logic signed [SUM_WIDTH-1:0]    sum_q, sum_d;
  logic                           cand_q, cand_d;
  logic                           done_q, done_d;
  logic                           busy_q, busy_d;
  logic                           ready_q, ready_d;
  logic                           ii_rd_q, ii_rd_d;
  logic [II_ADDR_WIDTH-1:0]       ii_addr_q, ii_addr_d;

  logic [II_WIDTH-1:0]            corner [NF];
  logic signed [VAL_W-1:0]        value;
  logic signed [DATA_WIDTH-1:0]   leaf;
  logic signed [ACC_W-1:0]        acc;
  logic signed [SUM_WIDTH-1:0]    sum_next;

  // The last corner of a record is still on ii_rdata during EVAL, so it bypasses the sample bank.
  always_comb begin
    logic signed [RECT_W-1:0]     rect;
    logic signed [DATA_WIDTH-1:0] weight;
    logic signed [VAL_W-1:0]      feat_thr;
    // NOTE: every variable written here gets a value on every path first, so no latch is inferred.
    rect   = '0;
    weight = '0;
    value  = '0;
    for (int i = 0; i < NF; i++) corner[i] = samp_q[i];
    corner[NF-1] = ii_rdata;
    for (int r = 0; r < NUM_RECTS; r++) begin
      rect = $signed({2'b00, corner[4*r]})   - $signed({2'b00, corner[4*r+1]})
           - $signed({2'b00, corner[4*r+2]}) + $signed({2'b00, corner[4*r+3]});
      weight = $signed(rec_q[5*r+4]);
      value  = value + VAL_W'(rect) * VAL_W'(weight);
    end
    feat_thr = VAL_W'($signed(rec_q[5*NUM_RECTS]));
    leaf = (value > feat_thr) ? $signed(rec_q[5*NUM_RECTS+2]) : $signed(rec_q[5*NUM_RECTS+1]);
  end

  always_comb begin
    acc = ACC_W'(sum_q) + ACC_W'(leaf);
`ifdef HAAR_SUM_SAT_EN
    if (acc > ACC_W'(SUM_POS))      sum_next = SUM_POS;
    else if (acc < ACC_W'(SUM_NEG)) sum_next = SUM_NEG;
    else                            sum_next = acc[SUM_WIDTH-1:0];
`else
    sum_next = acc[SUM_WIDTH-1:0];
`endif
  end

  always_comb begin
    logic [WC_W-1:0] sel;
    state_d     = state_q;
    rec_d       = rec_q;
    samp_d      = samp_q;
    word_cnt_d  = word_cnt_q;
    fetch_cnt_d = fetch_cnt_q;
    cls_left_d  = cls_left_q;
    stage_thr_d = stage_thr_q;
    sum_d       = sum_q;
    cand_d      = cand_q;
    unique case (state_q)
      S_IDLE: if (start) begin
        state_d    = S_HDR;
        word_cnt_d = '0;
        sum_d      = '0;
        cand_d     = 1'b0;
      end
      S_HDR: if (db_valid && ready_q) begin
        if (word_cnt_q == '0) begin
          stage_thr_d = db_data;
          word_cnt_d  = WC_W'(1);
        end else begin
          cls_left_d = COUNT_WIDTH'(db_data);
          word_cnt_d = '0;
          state_d    = (cls_left_d == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: if (db_valid && ready_q) begin
        rec_d[word_cnt_q] = db_data;
        if (word_cnt_q == WC_W'(W-1)) begin
          word_cnt_d  = '0;
          fetch_cnt_d = '0;
          state_d     = S_FETCH;
        end else begin
          word_cnt_d = word_cnt_q + WC_W'(1);
        end
      end
      S_FETCH: begin
        if (fetch_cnt_q != '0) samp_d[fetch_cnt_q - FC_W'(1)] = ii_rdata;
        if (fetch_cnt_q == FC_W'(NF-1)) state_d = S_EVAL;
        else fetch_cnt_d = fetch_cnt_q + FC_W'(1);
      end
      S_EVAL: begin
        samp_d[NF-1] = ii_rdata;
        sum_d        = sum_next;
        cls_left_d   = cls_left_q - COUNT_WIDTH'(1);
        state_d      = (cls_left_q == COUNT_WIDTH'(1)) ? S_DONE : S_LOAD;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_DONE && state_q != S_DONE)
      cand_d = ACC_W'(sum_d) > ACC_W'(stage_thr_q);

    // Outputs are decoded from the next state so they leave the flops aligned with the state.
    busy_d    = (state_d != S_IDLE);
    ready_d   = (state_d == S_HDR) || (state_d == S_LOAD);
    done_d    = (state_d == S_DONE);
    ii_rd_d   = (state_d == S_FETCH);
    sel       = WC_W'(5 * int'(fetch_cnt_d >> 2) + int'(fetch_cnt_d[1:0]));
    ii_addr_d = ii_rd_d ? II_ADDR_WIDTH'(rec_d[sel]) : '0;
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      // NOTE: record and sample banks are reset too, so an aborted stage leaves no stale data.
      for (int i = 0; i < W; i++)  rec_q[i]  <= '0;
      for (int i = 0; i < NF; i++) samp_q[i] <= '0;
      word_cnt_q  <= '0;
      fetch_cnt_q <= '0;
      cls_left_q  <= '0;
      stage_thr_q <= '0;
      sum_q       <= '0;
      cand_q      <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
      ii_rd_q     <= 1'b0;
      ii_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      rec_q       <= rec_d;
      samp_q      <= samp_d;
      word_cnt_q  <= word_cnt_d;
      fetch_cnt_q <= fetch_cnt_d;
      cls_left_q  <= cls_left_d;
      stage_thr_q <= stage_thr_d;
      sum_q       <= sum_d;
      cand_q      <= cand_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
      ii_rd_q     <= ii_rd_d;
      ii_addr_q   <= ii_addr_d;
    end
  end

  assign db_ready  = ready_q;
  assign ii_rd     = ii_rd_q;
  assign ii_addr   = ii_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign candidate = cand_q;
  assign stage_sum = sum_q;
endmodule
